// File: rtl/mem_pkg.sv
// Shared encodings and byte-lane helpers for the mem_block_ls load/store front end.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Widest line the helpers can describe; the mask window spans two lines.
  localparam int MAX_LANES = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SECOND = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Bytes touched by an access, placed across a two-line window starting at offset.
  function automatic logic [2*MAX_LANES-1:0] byte_mask(input logic [5:0] offset,
                                                       input logic [1:0] size);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001;
      SZ_HALF: m = 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return {{(2*MAX_LANES-4){1'b0}}, m} << offset;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                              input logic [1:0]  size,
                                              input logic        is_unsigned);
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = is_unsigned ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      SZ_HALF: r = is_unsigned ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_ram.sv
// Single-port byte-enabled line array with a registered read port; contents are not reset.
module mem_lane_ram #(
  parameter  int DEPTH = 512,
  parameter  int WIDTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               en_i,
  input  logic               we_i,
  input  logic [AW-1:0]      addr_i,
  input  logic [WIDTH-1:0]   be_i,
  input  logic [8*WIDTH-1:0] wdata_i,
  output logic [8*WIDTH-1:0] rdata_o
);

  logic [8*WIDTH-1:0] mem [DEPTH];
  logic [8*WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (en_i) rdata_d = mem[addr_i];
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (en_i && we_i) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_block_ls.sv
// RV32I data-memory controller: aligns, masks and sign-extends LB/LH/LW/SB/SH/SW over mem_lane_ram.
// Define MEM_BLOCK_LS_SPLIT_EN to split line-crossing accesses into two beats; otherwise they are rejected.
module mem_block_ls
  import mem_pkg::*;
#(
  parameter  int DEPTH  = 512,
  parameter  int WIDTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH*WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int OFF_W  = $clog2(WIDTH);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int LINE_W = 8 * WIDTH;

  state_e state_q, state_d;
  logic we_q, we_d, uns_q, uns_d, err_q, err_d;
  logic [1:0]       size_q, size_d;
  logic [OFF_W-1:0] off_q, off_d;

  logic [OFF_W-1:0]       off_in;
  logic [IDX_W-1:0]       idx_in;
  logic [2*MAX_LANES-1:0] mask_full;
  logic                   cross_in, bad_in, accept;
  logic [LINE_W-1:0]      wdata_lo;

  logic              ram_en, ram_we;
  logic [IDX_W-1:0]  ram_addr;
  logic [WIDTH-1:0]  ram_be;
  logic [LINE_W-1:0] ram_wdata, ram_rdata;

  logic [2*LINE_W-1:0] rd_win;
  logic [31:0]         rd_raw;

`ifdef MEM_BLOCK_LS_SPLIT_EN
  logic                cross_q, cross_d;
  logic [IDX_W-1:0]    idx2_q, idx2_d;
  logic [WIDTH-1:0]    hi_be_q, hi_be_d;
  logic [LINE_W-1:0]   hi_wdata_q, hi_wdata_d, hold_q, hold_d;
  logic [2*LINE_W-1:0] wdata_wide;
`endif

  always_comb begin
    off_in    = req_addr_i[OFF_W-1:0];
    idx_in    = req_addr_i[ADDR_W-1:OFF_W];
    mask_full = byte_mask(6'(off_in), req_size_i);
    cross_in  = |mask_full[2*MAX_LANES-1:WIDTH];
`ifdef MEM_BLOCK_LS_SPLIT_EN
    bad_in     = (req_size_i == SZ_RSVD);
    wdata_wide = (2*LINE_W)'(req_wdata_i) << {off_in, 3'b000};
    wdata_lo   = wdata_wide[LINE_W-1:0];
`else
    bad_in   = (req_size_i == SZ_RSVD) || cross_in;
    wdata_lo = LINE_W'(req_wdata_i) << {off_in, 3'b000};
`endif
  end

`ifdef MEM_BLOCK_LS_SPLIT_EN
  assign req_ready_o = rst_n_i && (state_q != SECOND);
`else
  assign req_ready_o = rst_n_i;
`endif
  assign accept = req_valid_i && req_ready_o;

  always_comb begin
    state_d = IDLE;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    err_d   = err_q;
`ifdef MEM_BLOCK_LS_SPLIT_EN
    cross_d    = cross_q;
    idx2_d     = idx2_q;
    hi_be_d    = hi_be_q;
    hi_wdata_d = hi_wdata_q;
    hold_d     = hold_q;
`endif
    if (accept) begin
      we_d   = req_we_i;
      size_d = req_size_i;
      uns_d  = req_unsigned_i;
      off_d  = off_in;
      err_d  = bad_in;
`ifdef MEM_BLOCK_LS_SPLIT_EN
      cross_d    = cross_in && !bad_in;
      idx2_d     = idx_in + IDX_W'(1);
      hi_be_d    = mask_full[2*WIDTH-1:WIDTH];
      hi_wdata_d = wdata_wide[2*LINE_W-1:LINE_W];
`endif
    end
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
`ifdef MEM_BLOCK_LS_SPLIT_EN
          state_d = cross_d ? SECOND : RESP;
`else
          state_d = RESP;
`endif
        end
      end
`ifdef MEM_BLOCK_LS_SPLIT_EN
      SECOND: begin
        state_d = RESP;
        hold_d  = ram_rdata;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Beat 1 goes out on the accept edge straight from the request; beat 2 from captured state.
  always_comb begin
    ram_en    = accept && !bad_in;
    ram_we    = req_we_i;
    ram_addr  = idx_in;
    ram_be    = mask_full[WIDTH-1:0];
    ram_wdata = wdata_lo;
`ifdef MEM_BLOCK_LS_SPLIT_EN
    if (rst_n_i && (state_q == SECOND)) begin
      ram_en    = 1'b1;
      ram_we    = we_q;
      ram_addr  = idx2_q;
      ram_be    = hi_be_q;
      ram_wdata = hi_wdata_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    we_q   <= we_d;
    size_q <= size_d;
    uns_q  <= uns_d;
    off_q  <= off_d;
    err_q  <= err_d;
`ifdef MEM_BLOCK_LS_SPLIT_EN
    cross_q    <= cross_d;
    idx2_q     <= idx2_d;
    hi_be_q    <= hi_be_d;
    hi_wdata_q <= hi_wdata_d;
    hold_q     <= hold_d;
`endif
  end

  mem_lane_ram #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) u_ram (
    .clk    (clk),
    .en_i   (ram_en),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .be_i   (ram_be),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  // Little-endian window: first line in the low half, second line above it.
  always_comb begin
    rd_win = {{LINE_W{1'b0}}, ram_rdata};
`ifdef MEM_BLOCK_LS_SPLIT_EN
    if (cross_q) rd_win = {ram_rdata, hold_q};
`endif
    rd_raw = 32'(rd_win >> {off_q, 3'b000});
  end

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_err_o   = rsp_valid_o && err_q;
  assign rsp_rdata_o = (rsp_valid_o && !we_q && !err_q) ? load_extend(rd_raw, size_q, uns_q) : 32'b0;

endmodule

// File: tb/tb_mem_block_ls.sv
// Self-checking bench for mem_block_ls: directed RV32I cases plus random traffic against a byte-array model.
module tb_mem_block_ls;

`ifdef MEM_BLOCK_LS_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [10:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [7:0]  mm [2048];
  logic [31:0] last_rd;
  logic        last_err;
  logic        last_rdy1;
  int          last_lat;
  logic [31:0] saved;

  always #5 clk = ~clk;

  mem_block_ls #(.DEPTH(512), .WIDTH(4)) dut (
    .clk           (clk),
    .rst_n_i       (rst_n_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_we_i      (req_we_i),
    .req_size_i    (req_size_i),
    .req_unsigned_i(req_unsigned_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_rdata_o   (rsp_rdata_o),
    .rsp_err_o     (rsp_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns, input logic [10:0] a);
    logic [31:0] v;
    int n;
    v = 32'd0;
    n = nbytes(sz);
    for (int i = 0; i < n; i++) v = v | (32'(mm[(int'(a) + i) % 2048]) << (8 * i));
    if (!uns && n == 1 && v >= 32'h80)   v = v | 32'hFFFF_FF00;
    if (!uns && n == 2 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic m_store(input logic [1:0] sz, input logic [10:0] a, input logic [31:0] wd);
    for (int i = 0; i < nbytes(sz); i++) mm[(int'(a) + i) % 2048] = wd[8*i +: 8];
  endtask

  // One request through the DUT, compared against the model; leaves results in last_*.
  task automatic access(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [10:0] a, input logic [31:0] wd);
    logic [31:0] e_rd;
    logic        e_err, pulse_next;
    int          e_lat, k;
    bit          crs;
    crs   = (int'(a % 4) + nbytes(sz)) > 4;
    e_err = (sz == 2'd3) || (crs && !SPLIT);
    e_lat = (!e_err && crs) ? 2 : 1;
    e_rd  = (we || e_err) ? 32'd0 : m_load(sz, uns, a);
    @(negedge clk);
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = sz;
    req_unsigned_i = uns;
    req_addr_i     = a;
    req_wdata_i    = wd;
    k = 0;
    while (!req_ready_o && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_ready"}, 32'(req_ready_o), 32'd1);
    @(posedge clk);
    #1;
    req_valid_i    = 1'b0;
    req_we_i       = 1'($urandom);
    req_size_i     = 2'($urandom);
    req_unsigned_i = 1'($urandom);
    req_addr_i     = 11'($urandom);
    req_wdata_i    = $urandom;
    last_lat  = 99;
    last_rd   = 32'd0;
    last_err  = 1'b0;
    last_rdy1 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) last_rdy1 = req_ready_o;
      if (rsp_valid_o) begin
        last_lat = c;
        last_rd  = rsp_rdata_o;
        last_err = rsp_err_o;
        break;
      end
    end
    @(negedge clk);
    pulse_next = rsp_valid_o;
    chk({tag, "_lat"},   32'(last_lat), 32'(e_lat));
    chk({tag, "_rdata"}, last_rd, e_rd);
    chk({tag, "_err"},   32'(last_err), 32'(e_err));
    chk({tag, "_pulse"}, 32'(pulse_next), 32'd0);
    chk({tag, "_rdy1"},  32'(last_rdy1), 32'(e_lat == 1));
    if (we && !e_err) m_store(sz, a, wd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_i        = 1'b0;
    req_valid_i    = 1'b0;
    req_we_i       = 1'b0;
    req_size_i     = 2'd0;
    req_unsigned_i = 1'b0;
    req_addr_i     = 11'd0;
    req_wdata_i    = 32'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rdata", rsp_rdata_o, 32'd0);
    chk("rst_err",   32'(rsp_err_o), 32'd0);
    rst_n_i = 1'b1;
    #1;
    chk("rel_ready", 32'(req_ready_o), 32'd1);

    // Give every line a defined random value
    for (int l = 0; l < 512; l++) access("fill", 1'b1, 2'd2, 1'b0, 11'(l * 4), $urandom);

    access("sw10", 1'b1, 2'd2, 1'b0, 11'h010, 32'hDEAD_BEEF);
    access("lw10", 1'b0, 2'd2, 1'b0, 11'h010, 32'd0);
    chk("lw10_val", last_rd, 32'hDEAD_BEEF);
    access("lb13", 1'b0, 2'd0, 1'b0, 11'h013, 32'd0);
    chk("lb13_val", last_rd, 32'hFFFF_FFDE);
    access("lbu13", 1'b0, 2'd0, 1'b1, 11'h013, 32'd0);
    chk("lbu13_val", last_rd, 32'h0000_00DE);
    access("lh12", 1'b0, 2'd1, 1'b0, 11'h012, 32'd0);
    chk("lh12_val", last_rd, 32'hFFFF_DEAD);
    access("lhu12", 1'b0, 2'd1, 1'b1, 11'h012, 32'd0);
    chk("lhu12_val", last_rd, 32'h0000_DEAD);
    access("lw10_uns", 1'b0, 2'd2, 1'b1, 11'h010, 32'd0);
    chk("lw10_uns_val", last_rd, 32'hDEAD_BEEF);

    // Line-crossing word store and loads
    access("sw14", 1'b1, 2'd2, 1'b0, 11'h014, 32'd0);
    access("sw18", 1'b1, 2'd2, 1'b0, 11'h018, 32'd0);
    access("sw16", 1'b1, 2'd2, 1'b0, 11'h016, 32'h1122_3344);
    chk("sw16_rdy1", 32'(last_rdy1), SPLIT ? 32'd0 : 32'd1);
    access("lw14", 1'b0, 2'd2, 1'b0, 11'h014, 32'd0);
    chk("lw14_val", last_rd, SPLIT ? 32'h3344_0000 : 32'd0);
    access("lw18", 1'b0, 2'd2, 1'b0, 11'h018, 32'd0);
    chk("lw18_val", last_rd, SPLIT ? 32'h0000_1122 : 32'd0);
    access("lw16", 1'b0, 2'd2, 1'b0, 11'h016, 32'd0);
    chk("lw16_val", last_rd, SPLIT ? 32'h1122_3344 : 32'd0);
    chk("lw16_lat", 32'(last_lat), SPLIT ? 32'd2 : 32'd1);

    // Halfword wrapping from the last line to line 0
    access("sh7ff", 1'b1, 2'd1, 1'b0, 11'h7FF, 32'h0000_ABCD);
    saved = m_load(2'd0, 1'b1, 11'h7FF);
    access("lbu7ff", 1'b0, 2'd0, 1'b1, 11'h7FF, 32'd0);
    chk("lbu7ff_val", last_rd, SPLIT ? 32'h0000_00CD : saved);
    saved = m_load(2'd0, 1'b1, 11'h000);
    access("lbu000", 1'b0, 2'd0, 1'b1, 11'h000, 32'd0);
    chk("lbu000_val", last_rd, SPLIT ? 32'h0000_00AB : saved);

    // Reserved size is rejected without touching the array
    saved = m_load(2'd2, 1'b0, 11'h020);
    access("rsvd20", 1'b1, 2'd3, 1'b0, 11'h020, 32'h1234_5678);
    chk("rsvd20_err", 32'(last_err), 32'd1);
    chk("rsvd20_rd",  last_rd, 32'd0);
    access("lw20", 1'b0, 2'd2, 1'b0, 11'h020, 32'd0);
    chk("lw20_val", last_rd, saved);

    // Reset while the second beat is pending
    @(negedge clk);
    req_valid_i    = 1'b1;
    req_we_i       = 1'b1;
    req_size_i     = 2'd2;
    req_unsigned_i = 1'b0;
    req_addr_i     = 11'h016;
    req_wdata_i    = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    rst_n_i     = 1'b0;
    @(negedge clk);
    chk("rst2_valid", 32'(rsp_valid_o), SPLIT ? 32'd0 : 32'd1);
    chk("rst2_ready", 32'(req_ready_o), 32'd0);
    @(negedge clk);
    chk("rst2_valid_b", 32'(rsp_valid_o), 32'd0);
    rst_n_i = 1'b1;
    #1;
    chk("rst2_ready_rel", 32'(req_ready_o), 32'd1);
    @(negedge clk);
    chk("rst2_valid_c", 32'(rsp_valid_o), 32'd0);
    mm[11'h016] = SPLIT ? 8'h0D : mm[11'h016];
    mm[11'h017] = SPLIT ? 8'hF0 : mm[11'h017];
    access("lw14b", 1'b0, 2'd2, 1'b0, 11'h014, 32'd0);
    chk("lw14b_val", last_rd, SPLIT ? 32'hF00D_0000 : 32'd0);
    access("lw18b", 1'b0, 2'd2, 1'b0, 11'h018, 32'd0);
    chk("lw18b_val", last_rd, SPLIT ? 32'h0000_1122 : 32'd0);

    // Random traffic, biased toward the wrap point
    for (int r = 0; r < 200; r++) begin
      logic [10:0] a;
      a = ($urandom_range(0, 3) == 0) ? 11'(11'h7FC + 11'($urandom_range(0, 3))) : 11'($urandom);
      access("rnd", 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
